// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter: data width, register address and write request.
package regfile_wb_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_adr_t;

    typedef struct packed {
        reg_adr_t          rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests holding late results until the rf write port is free.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    Rst,
    input  logic    push,
    input  wb_req_t din,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback and buffered late results onto the single rf write port, with busy scoreboard.
// Define REGFILE_WB_BYPASS_EN to let a late result skip the empty FIFO when the pipe slot is idle.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            pipe_regwrite,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            lat_valid,
    output logic            lat_ready,
    input  logic [4:0]      lat_rd,
    input  logic [XLEN-1:0] lat_data,
    output logic            rf_regwrite,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data,
    output logic [31:0]     busy_vec,
    output logic            fifo_full
);
    import regfile_wb_pkg::*;

    wb_req_t     lat_req;
    wb_req_t     fifo_head;
    wb_req_t     sel_req;
    logic        fifo_empty;
    logic        pipe_take;
    logic        lat_fire;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        sel_valid;
    logic        sel_late;
    logic [31:0] busy_q;
    logic [31:0] busy_nxt;

    assign lat_ready = !fifo_full;
    assign pipe_take = pipe_regwrite && (pipe_rd != '0);
    // rd 0 late results are handshaken but never stored.
    assign lat_fire  = lat_valid && lat_ready && (lat_rd != '0);
    assign lat_req   = '{rd: lat_rd, data: lat_data};

`ifdef REGFILE_WB_BYPASS_EN
    assign bypass = lat_fire && fifo_empty && !pipe_take;
`else
    assign bypass = 1'b0;
`endif

    assign push = lat_fire && !bypass;
    assign pop  = !pipe_take && !fifo_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (push),
        .din   (lat_req),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_late  = 1'b0;
        sel_req   = '0;
        if (pipe_take) begin
            sel_valid = 1'b1;
            sel_req   = '{rd: pipe_rd, data: pipe_data};
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_late  = 1'b1;
            sel_req   = fifo_head;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_late  = 1'b1;
            sel_req   = lat_req;
        end
    end

    // Clear before set so a same-cycle issue to the completing rd keeps it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (sel_late) begin
            busy_nxt[sel_req.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            rf_regwrite <= 1'b0;
            rf_rd       <= '0;
            rf_data     <= '0;
            busy_q      <= '0;
        end else begin
            rf_regwrite <= sel_valid;
            if (sel_valid) begin
                rf_rd   <= sel_req.rd;
                rf_data <= sel_req.data;
            end
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = busy_q;

    a_no_pipe_write_to_busy: assert property (
        @(posedge clk) disable iff (Rst) !(pipe_take && busy_q[pipe_rd])
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized run against a queue model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Rst;
    logic        pipe_regwrite;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        lat_valid;
    logic        lat_ready;
    logic [4:0]  lat_rd;
    logic [31:0] lat_data;
    logic        rf_regwrite;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] busy_vec;
    logic        fifo_full;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit   [31:0] m_busy;
    bit          exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    regfile_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .Rst           (Rst),
        .pipe_regwrite (pipe_regwrite),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .lat_valid     (lat_valid),
        .lat_ready     (lat_ready),
        .lat_rd        (lat_rd),
        .lat_data      (lat_data),
        .rf_regwrite   (rf_regwrite),
        .rf_rd         (rf_rd),
        .rf_data       (rf_data),
        .busy_vec      (busy_vec),
        .fifo_full     (fifo_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rst           = 1'b0;
        pipe_regwrite = 1'b0;
        pipe_rd       = '0;
        pipe_data     = '0;
        issue_valid   = 1'b0;
        issue_rd      = '0;
        lat_valid     = 1'b0;
        lat_rd        = '0;
        lat_data      = '0;
    endtask

    // One cycle of the reference: pipe first, then oldest buffered result, then (bypass) fresh result.
    task automatic model_step();
        ent_t e;
        ent_t h;
        bit   have_e;
        if (Rst) begin
            m_q.delete();
            m_busy   = '0;
            exp_we   = 1'b0;
            exp_rd   = '0;
            exp_data = '0;
            return;
        end
        have_e = lat_valid && (m_q.size() < DEPTH) && (lat_rd != 5'd0);
        e.rd   = lat_rd;
        e.data = lat_data;
        exp_we = 1'b1;
        if (pipe_regwrite && pipe_rd != 5'd0) begin
            exp_rd   = pipe_rd;
            exp_data = pipe_data;
        end else if (m_q.size() > 0) begin
            h        = m_q.pop_front();
            exp_rd   = h.rd;
            exp_data = h.data;
            m_busy[h.rd] = 1'b0;
        end else if (BYP && have_e) begin
            exp_rd   = e.rd;
            exp_data = e.data;
            m_busy[e.rd] = 1'b0;
            have_e   = 1'b0;
        end else begin
            exp_we = 1'b0;
        end
        if (have_e) m_q.push_back(e);
        if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL reset_we actual=%b required=0", rf_regwrite); else n_pass++;
        n_checks++; if (rf_rd !== 5'd0) $display("FAIL reset_rd actual=%0d required=0", rf_rd); else n_pass++;
        n_checks++; if (rf_data !== 32'd0) $display("FAIL reset_data actual=%h required=0", rf_data); else n_pass++;
        n_checks++; if (busy_vec !== 32'd0) $display("FAIL reset_busy actual=%h required=0", busy_vec); else n_pass++;
        n_checks++; if (fifo_full !== 1'b0) $display("FAIL reset_full actual=%b required=0", fifo_full); else n_pass++;
        n_checks++; if (lat_ready !== 1'b1) $display("FAIL reset_ready actual=%b required=1", lat_ready); else n_pass++;
    endtask

    task automatic test_pipe_write();
        idle();
        pipe_regwrite = 1'b1;
        pipe_rd       = 5'd5;
        pipe_data     = 32'hDEADBEEF;
        tick();
        idle();
        n_checks++; if (rf_regwrite !== 1'b1) $display("FAIL pipe_we actual=%b required=1", rf_regwrite); else n_pass++;
        n_checks++; if (rf_rd !== 5'd5) $display("FAIL pipe_rd actual=%0d required=5", rf_rd); else n_pass++;
        n_checks++; if (rf_data !== 32'hDEADBEEF) $display("FAIL pipe_data actual=%h required=deadbeef", rf_data); else n_pass++;
        tick();
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL pipe_idle_we actual=%b required=0", rf_regwrite); else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        idle();
        n_checks++; if (busy_vec[7] !== 1'b1) $display("FAIL sb_set actual=%b required=1", busy_vec[7]); else n_pass++;
        tick();
        tick();
        n_checks++; if (busy_vec[7] !== 1'b1) $display("FAIL sb_hold actual=%b required=1", busy_vec[7]); else n_pass++;
        lat_valid = 1'b1;
        lat_rd    = 5'd7;
        lat_data  = 32'h12;
        tick();
        idle();
`ifndef REGFILE_WB_BYPASS_EN
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL sb_queued_we actual=%b required=0", rf_regwrite); else n_pass++;
        n_checks++; if (busy_vec[7] !== 1'b1) $display("FAIL sb_queued_busy actual=%b required=1", busy_vec[7]); else n_pass++;
        tick();
`endif
        n_checks++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h12)
            $display("FAIL sb_write actual=%b/%0d/%h required=1/7/12", rf_regwrite, rf_rd, rf_data); else n_pass++;
        n_checks++; if (busy_vec[7] !== 1'b0) $display("FAIL sb_clear actual=%b required=0", busy_vec[7]); else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [31:0] pd;
        idle();
        for (int i = 0; i < 4; i++) begin
            pd            = $urandom;
            pipe_regwrite = 1'b1;
            pipe_rd       = 5'(10 + i);
            pipe_data     = pd;
            lat_valid     = 1'b1;
            lat_rd        = 5'(i + 1);
            lat_data      = 32'hA0 + 32'(i);
            n_checks++; if (lat_ready !== 1'b1) $display("FAIL ff_ready%0d actual=%b required=1", i, lat_ready); else n_pass++;
            tick();
            n_checks++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'(10 + i) || rf_data !== pd)
                $display("FAIL ff_pipe%0d actual=%b/%0d/%h required=1/%0d/%h", i, rf_regwrite, rf_rd, rf_data, 10 + i, pd); else n_pass++;
        end
        n_checks++; if (fifo_full !== 1'b1) $display("FAIL ff_full actual=%b required=1", fifo_full); else n_pass++;
        pipe_rd   = 5'd14;
        pipe_data = 32'h14;
        lat_rd    = 5'd5;
        lat_data  = 32'hA5;
        n_checks++; if (lat_ready !== 1'b0) $display("FAIL ff_ready_full actual=%b required=0", lat_ready); else n_pass++;
        tick();
        idle();
        n_checks++; if (rf_rd !== 5'd14) $display("FAIL ff_pipe5 actual=%0d required=14", rf_rd); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'(i + 1) || rf_data !== 32'hA0 + 32'(i))
                $display("FAIL ff_drain%0d actual=%b/%0d/%h required=1/%0d/%h", i, rf_regwrite, rf_rd, rf_data, i + 1, 32'hA0 + 32'(i)); else n_pass++;
        end
        tick();
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL ff_empty_we actual=%b required=0", rf_regwrite); else n_pass++;
        n_checks++; if (fifo_full !== 1'b0) $display("FAIL ff_empty_full actual=%b required=0", fifo_full); else n_pass++;
    endtask

    task automatic test_rd_zero();
        idle();
        pipe_regwrite = 1'b1;
        pipe_rd       = 5'd0;
        pipe_data     = 32'hFF;
        lat_valid     = 1'b1;
        lat_rd        = 5'd0;
        lat_data      = 32'h55;
        tick();
        idle();
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL rd0_we actual=%b required=0", rf_regwrite); else n_pass++;
        tick();
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL rd0_noenq actual=%b required=0", rf_regwrite); else n_pass++;
        n_checks++; if (busy_vec[0] !== 1'b0) $display("FAIL rd0_busy actual=%b required=0", busy_vec[0]); else n_pass++;
    endtask

    task automatic test_set_wins();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        idle();
        n_checks++; if (busy_vec[9] !== 1'b1) $display("FAIL sw_set actual=%b required=1", busy_vec[9]); else n_pass++;
        lat_valid = 1'b1;
        lat_rd    = 5'd9;
        lat_data  = 32'h99;
`ifdef REGFILE_WB_BYPASS_EN
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        idle();
`else
        tick();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL sw_queued actual=%b required=0", rf_regwrite); else n_pass++;
        tick();
        idle();
`endif
        n_checks++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h99)
            $display("FAIL sw_write actual=%b/%0d/%h required=1/9/99", rf_regwrite, rf_rd, rf_data); else n_pass++;
        n_checks++; if (busy_vec[9] !== 1'b1) $display("FAIL sw_busy actual=%b required=1", busy_vec[9]); else n_pass++;
        tick();
        n_checks++; if (busy_vec[9] !== 1'b1) $display("FAIL sw_busy_hold actual=%b required=1", busy_vec[9]); else n_pass++;
    endtask

    task automatic test_reset_midop();
        idle();
        for (int i = 0; i < 3; i++) begin
            pipe_regwrite = 1'b1;
            pipe_rd       = 5'(20 + i);
            pipe_data     = $urandom;
            issue_valid   = 1'b1;
            issue_rd      = 5'(i + 1);
            lat_valid     = 1'b1;
            lat_rd        = 5'(i + 1);
            lat_data      = $urandom;
            tick();
        end
        idle();
        n_checks++; if (busy_vec[3:1] !== 3'b111) $display("FAIL rm_busy_pre actual=%b required=111", busy_vec[3:1]); else n_pass++;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        n_checks++; if (busy_vec !== 32'd0) $display("FAIL rm_busy actual=%h required=0", busy_vec); else n_pass++;
        n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL rm_we actual=%b required=0", rf_regwrite); else n_pass++;
        n_checks++; if (fifo_full !== 1'b0 || lat_ready !== 1'b1) $display("FAIL rm_fifo actual=%b/%b required=0/1", fifo_full, lat_ready); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL rm_nowrite%0d actual=%b required=0", i, rf_regwrite); else n_pass++;
        end
    endtask

    task automatic test_random();
        idle();
        Rst = 1'b1;
        model_step();
        tick();
        for (int c = 0; c < 600; c++) begin
            idle();
            Rst           = ($urandom_range(0, 79) == 0);
            pipe_rd       = 5'($urandom_range(0, 15));
            pipe_regwrite = ($urandom_range(0, 99) < 45) && !m_busy[pipe_rd];
            pipe_data     = $urandom;
            issue_valid   = ($urandom_range(0, 99) < 25);
            issue_rd      = 5'($urandom_range(0, 15));
            lat_valid     = ($urandom_range(0, 99) < 55);
            lat_rd        = 5'($urandom_range(0, 15));
            lat_data      = $urandom;
            n_checks++; if (lat_ready !== (m_q.size() < DEPTH))
                $display("FAIL rnd_ready c=%0d actual=%b required=%b", c, lat_ready, m_q.size() < DEPTH); else n_pass++;
            model_step();
            tick();
            n_checks++; if (rf_regwrite !== exp_we)
                $display("FAIL rnd_we c=%0d actual=%b required=%b", c, rf_regwrite, exp_we); else n_pass++;
            if (exp_we) begin
                n_checks++; if (rf_rd !== exp_rd || rf_data !== exp_data)
                    $display("FAIL rnd_wr c=%0d actual=%0d/%h required=%0d/%h", c, rf_rd, rf_data, exp_rd, exp_data); else n_pass++;
            end
            n_checks++; if (busy_vec !== m_busy)
                $display("FAIL rnd_busy c=%0d actual=%h required=%h", c, busy_vec, m_busy); else n_pass++;
            n_checks++; if (fifo_full !== (m_q.size() == DEPTH))
                $display("FAIL rnd_full c=%0d actual=%b required=%b", c, fifo_full, m_q.size() == DEPTH); else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_pipe_write();
        test_scoreboard();
        test_fifo_full();
        test_rd_zero();
        test_set_wins();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
